// File: rtl/dz_pkg.sv
// DZ-11 receiver-wide constants, scanner state encoding and the silo entry layout.
// Shared by the scanner top and its silo FIFO.
package dz_pkg;

  localparam int NUM_LINES   = 8;
  localparam int SILO_DEPTH  = 64;
  localparam int ALARM_LEVEL = 16;

  localparam int LINE_W  = $clog2(NUM_LINES);
  localparam int PTR_W   = $clog2(SILO_DEPTH);
  localparam int ALARM_W = $clog2(ALARM_LEVEL) + 1;

  localparam int RBUF_VALID   = 15;
  localparam int RBUF_OVRE    = 14;
  localparam int RBUF_FRME    = 13;
  localparam int RBUF_PARE    = 12;
  localparam int RBUF_LINE_HI = 10;
  localparam int RBUF_LINE_LO = 8;
  localparam int RBUF_DATA_HI = 7;
  localparam int RBUF_DATA_LO = 0;

  typedef enum logic [1:0] {IDLE, SCAN, LOAD, SETTLE} scan_state_e;

  typedef struct packed {
    logic              ovre;
    logic              frme;
    logic              pare;
    logic [LINE_W-1:0] line;
    logic [7:0]        data;
  } silo_entry_t;

  localparam int ENTRY_W = $bits(silo_entry_t);

  // Formats a silo entry as the RBUF word; an invalid head reads as all zeros.
  function automatic logic [15:0] rbuf_word(input logic valid, input silo_entry_t e);
    logic [15:0] w;
    w = '0;
    if (valid) begin
      w[RBUF_VALID]                = 1'b1;
      w[RBUF_OVRE]                 = e.ovre;
      w[RBUF_FRME]                 = e.frme;
      w[RBUF_PARE]                 = e.pare;
      w[RBUF_LINE_HI:RBUF_LINE_LO] = e.line;
      w[RBUF_DATA_HI:RBUF_DATA_LO] = e.data;
    end
    return w;
  endfunction

endpackage

// File: rtl/dz_silo.sv
// Synchronous first-word-fall-through FIFO holding received characters.
// The head is a registered RAM read at the next read address, with a bypass for pushes into an emptying silo.
module dz_silo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW-1:0]    rd_ptr_next;
  logic [PW:0]      count_reg;
  logic [PW:0]      count_next;
  logic [WIDTH-1:0] dout_reg;
  logic             push_ok;
  logic             pop_ok;
  logic             bypass;

  assign push_ok     = push && (count_reg != FULL_CNT);
  assign pop_ok      = pop && (count_reg != '0);
  assign rd_ptr_next = rd_ptr_reg + PW'(pop_ok);
  // The pushed word becomes the head only when nothing else remains after this edge's pop.
  assign bypass      = push_ok && ((count_reg == '0) || (pop_ok && (count_reg == (PW+1)'(1))));

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + (PW+1)'(1);
      2'b01:   count_next = count_reg - (PW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      dout_reg   <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      dout_reg   <= bypass ? din : mem[rd_ptr_next];
    end
  end

  assign dout  = dout_reg;
  assign count = count_reg;
  assign empty = (count_reg == '0);
  assign full  = (count_reg == FULL_CNT);

endmodule

// File: rtl/dz_rx_scanner.sv
// DZ-11 receiver scanner: polls the UART lines round-robin, loads characters into the silo,
// and presents the silo head as RBUF together with the RDONE and silo-alarm flags.
module dz_rx_scanner
  import dz_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   mse,
  input  logic [NUM_LINES-1:0]   rxfull,
  input  logic [8*NUM_LINES-1:0] rxdata,
  input  logic [NUM_LINES-1:0]   rxpare,
  input  logic [NUM_LINES-1:0]   rxfrme,
  input  logic [NUM_LINES-1:0]   rxovre,
  output logic [NUM_LINES-1:0]   rxclr,
  input  logic                   rbufRD,
  output logic [15:0]            rbufDATA,
  output logic                   rdone,
  output logic                   sa
);

  logic             srst;
  logic [7:0]       line_data [NUM_LINES];
  scan_state_e      state_reg;
  logic [LINE_W-1:0] idx_reg;
  logic [NUM_LINES-1:0] rxclr_reg;
  logic             push_reg;
  silo_entry_t      entry_reg;
  logic [ALARM_W-1:0] alarm_reg;

  logic [ENTRY_W-1:0] silo_dout;
  logic             silo_empty;
  logic             silo_full;
  logic [PTR_W:0]   silo_count;
  logic             rd_ok;
  silo_entry_t      head;

  assign srst = rst | clr;

  generate
    for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
      assign line_data[gi] = rxdata[8*gi +: 8];
    end
  endgenerate

  // The write and the rxclr pulse are both issued from the LOAD cycle's registers, so a
  // scan-enable drop during LOAD cannot cut either short.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      rxclr_reg <= '0;
      push_reg  <= 1'b0;
      entry_reg <= '0;
    end else begin
      rxclr_reg <= '0;
      push_reg  <= 1'b0;
      if (!mse) begin
        state_reg <= IDLE;
        idx_reg   <= '0;
      end else begin
        case (state_reg)
          IDLE: state_reg <= SCAN;
          SCAN: begin
            if (rxfull[idx_reg] && !silo_full) begin
              state_reg <= LOAD;
              push_reg  <= 1'b1;
              rxclr_reg <= {{(NUM_LINES-1){1'b0}}, 1'b1} << idx_reg;
              entry_reg <= '{ovre: rxovre[idx_reg], frme: rxfrme[idx_reg],
                             pare: rxpare[idx_reg], line: idx_reg,
                             data: line_data[idx_reg]};
            end else begin
              idx_reg <= idx_reg + LINE_W'(1);
            end
          end
          LOAD: state_reg <= SETTLE;
          SETTLE: begin
            idx_reg   <= idx_reg + LINE_W'(1);
            state_reg <= SCAN;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  dz_silo #(
    .WIDTH (ENTRY_W),
    .DEPTH (SILO_DEPTH)
  ) u_silo (
    .clk   (clk),
    .rst   (srst),
    .push  (push_reg),
    .pop   (rbufRD),
    .din   (entry_reg),
    .dout  (silo_dout),
    .empty (silo_empty),
    .full  (silo_full),
    .count (silo_count)
  );

  assign rd_ok = rbufRD && !silo_empty;

  always_ff @(posedge clk) begin
    if (srst) begin
      alarm_reg <= '0;
    end else if (rd_ok) begin
      alarm_reg <= push_reg ? ALARM_W'(1) : '0;
    end else if (push_reg && (alarm_reg != ALARM_W'(ALARM_LEVEL))) begin
      alarm_reg <= alarm_reg + ALARM_W'(1);
    end
  end

  assign head     = silo_entry_t'(silo_dout);
  assign rdone    = (silo_count != '0);
  assign rbufDATA = rbuf_word(rdone, head);
  assign sa       = (alarm_reg == ALARM_W'(ALARM_LEVEL));
  assign rxclr    = rxclr_reg;

endmodule

// File: tb/tb_dz_rx_scanner.sv
// Directed bench for dz_rx_scanner: a UART stand-in feeds characters, a queue holds the
// expected RBUF words in arrival order and each RBUF read is compared against its head.
module tb_dz_rx_scanner;
  import dz_pkg::*;

  logic        clk = 1'b0;
  logic        rst, clr, mse, rbufRD;
  logic [7:0]  rxfull, rxpare, rxfrme, rxovre, rxclr;
  logic [63:0] rxdata;
  logic [15:0] rbufDATA;
  logic        rdone, sa;

  int checks = 0;
  int errors = 0;
  int wide_pulse = 0;
  int clr_cnt [8];
  logic [7:0]  rxclr_prev = '0;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  dz_rx_scanner dut (
    .clk(clk), .rst(rst), .clr(clr), .mse(mse),
    .rxfull(rxfull), .rxdata(rxdata), .rxpare(rxpare), .rxfrme(rxfrme), .rxovre(rxovre),
    .rxclr(rxclr), .rbufRD(rbufRD), .rbufDATA(rbufDATA), .rdone(rdone), .sa(sa)
  );

  // One cycle; also acts as the UARTs, dropping a line's full flag when it is cleared.
  task automatic tick();
    @(negedge clk);
    for (int n = 0; n < 8; n++) begin
      if (rxclr[n]) begin
        clr_cnt[n]++;
        if (rxclr_prev[n]) wide_pulse++;
        rxfull[n] = 1'b0;
      end
    end
    rxclr_prev = rxclr;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic arm(input int line, input logic [7:0] data, input logic pe, input logic fe,
                     input logic oe, input logic expect_it);
    rxdata[line*8 +: 8] = data;
    rxpare[line] = pe;
    rxfrme[line] = fe;
    rxovre[line] = oe;
    rxfull[line] = 1'b1;
    if (expect_it) exp_q.push_back({1'b1, oe, fe, pe, 1'b0, 3'(line), data});
  endtask

  task automatic wait_drain(input string tag);
    int b = 0;
    while (rxfull != 8'h00 && b < 300) begin
      tick();
      b++;
    end
    check(tag, {15'b0, rxfull == 8'h00}, 16'h0001);
    tick();
    tick();
  endtask

  task automatic read_check(input string tag);
    logic [15:0] e;
    e = (exp_q.size() == 0) ? 16'h0000 : exp_q.pop_front();
    check(tag, rbufDATA, e);
    $display("read %s rbuf=%h", tag, rbufDATA);
    rbufRD = 1'b1;
    tick();
    rbufRD = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0; mse = 1'b0; rbufRD = 1'b0;
    rxfull = '0; rxpare = '0; rxfrme = '0; rxovre = '0; rxdata = '0;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    for (int n = 0; n < 8; n++) clr_cnt[n] = 0;
  endtask

  initial begin
    int b;
    int saved;

    // 1: reset state, then a single character on line 3
    do_reset();
    check("rst_rbuf", rbufDATA, 16'h0000);
    check("rst_rdone", {15'b0, rdone}, 16'h0000);
    check("rst_sa", {15'b0, sa}, 16'h0000);
    check("rst_rxclr", {8'b0, rxclr}, 16'h0000);
    mse = 1'b1;
    arm(3, 8'h41, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_drain("t1_drain");
    check("t1_clr_cnt", 16'(clr_cnt[3]), 16'd1);
    check("t1_rdone", {15'b0, rdone}, 16'h0001);
    check("t1_const", rbufDATA, 16'h8341);
    read_check("t1_rbuf");
    check("t1_rdone_after", {15'b0, rdone}, 16'h0000);

    // 2: three lines at once land in scan order
    do_reset();
    arm(0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b1);
    arm(5, 8'h35, 1'b0, 1'b0, 1'b0, 1'b1);
    arm(7, 8'h37, 1'b0, 1'b0, 1'b0, 1'b1);
    mse = 1'b1;
    wait_drain("t2_drain");
    read_check("t2_first");
    read_check("t2_second");
    read_check("t2_third");
    check("t2_rdone_empty", {15'b0, rdone}, 16'h0000);
    check("t2_rbuf_empty", rbufDATA, 16'h0000);

    // 3: error flags carried through
    arm(2, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_drain("t3_drain");
    check("t3_const", rbufDATA, 16'hB27F);
    read_check("t3_rbuf");

    // 4: full silo leaves the character in the UART until a slot frees up
    do_reset();
    mse = 1'b1;
    for (int i = 0; i < 64; i++) begin
      arm(i % 8, 8'(i + 8'h10), 1'b0, 1'b0, (i % 5) == 0, 1'b1);
      wait_drain("t4_fill");
    end
    check("t4_sa_full", {15'b0, sa}, 16'h0001);
    saved = clr_cnt[1];
    arm(1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) tick();
    check("t4_no_clr", 16'(clr_cnt[1] - saved), 16'd0);
    check("t4_held", {15'b0, rxfull[1]}, 16'h0001);
    read_check("t4_pop0");
    check("t4_sa_cleared", {15'b0, sa}, 16'h0000);
    b = 0;
    while (rxfull[1] && b < 12) begin
      tick();
      b++;
    end
    check("t4_clr_in_pass", {15'b0, !rxfull[1]}, 16'h0001);
    tick();
    tick();
    for (int i = 0; i < 64; i++) read_check("t4_drain_read");
    check("t4_rdone_empty", {15'b0, rdone}, 16'h0000);

    // 5: silo alarm at 16 loads, cleared by a read, raised again after 16 more
    do_reset();
    mse = 1'b1;
    for (int i = 0; i < 15; i++) begin
      arm(i % 8, 8'(i), 1'b0, 1'b0, 1'b0, 1'b1);
      wait_drain("t5_load");
    end
    check("t5_sa_15", {15'b0, sa}, 16'h0000);
    arm(6, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_drain("t5_load16");
    check("t5_sa_16", {15'b0, sa}, 16'h0001);
    read_check("t5_read");
    check("t5_sa_read", {15'b0, sa}, 16'h0000);
    for (int i = 0; i < 15; i++) begin
      arm((i + 3) % 8, 8'(i + 8'h80), 1'b0, 1'b0, 1'b0, 1'b1);
      wait_drain("t5_reload");
    end
    check("t5_sa_15b", {15'b0, sa}, 16'h0000);
    arm(0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_drain("t5_reload16");
    check("t5_sa_16b", {15'b0, sa}, 16'h0001);

    // 6: scan enable dropped during LOAD, then clr with five entries
    do_reset();
    mse = 1'b1;
    arm(4, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1);
    b = 0;
    while (clr_cnt[4] == 0 && b < 50) begin
      tick();
      b++;
    end
    check("t6_load_seen", 16'(clr_cnt[4]), 16'd1);
    mse = 1'b0;
    tick();
    check("t6_written", rbufDATA, 16'h8444);
    check("t6_clr_once", 16'(clr_cnt[4]), 16'd1);
    arm(5, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) tick();
    check("t6_idle_held", {15'b0, rxfull[5]}, 16'h0001);
    check("t6_idle_no_clr", 16'(clr_cnt[5]), 16'd0);
    mse = 1'b1;
    arm(1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
    arm(2, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
    arm(6, 8'h66, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_drain("t6_drain");
    check("t6_head", rbufDATA, exp_q[0]);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    mse = 1'b0;
    exp_q.delete();
    check("t6_clr_rdone", {15'b0, rdone}, 16'h0000);
    check("t6_clr_rbuf", rbufDATA, 16'h0000);
    check("t6_clr_sa", {15'b0, sa}, 16'h0000);
    tick();
    check("t6_clr_rbuf_hold", rbufDATA, 16'h0000);

    check("rxclr_width", 16'(wide_pulse), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
